// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SAVE   = 2'd1,
        VECTOR = 2'd2
    } pctl_state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_VEC = 2'b10;

    // Interrupt return address register written by the store-current path.
    localparam logic [3:0] R15_ADDR = 4'hf;

endpackage

// File: rtl/mem_watchdog.sv
// Memory-stall watchdog: counts consecutive busy cycles and raises a sticky
// timeout once the count reaches WAIT_TO. WAIT_TO must lie in 1..65535.
module mem_watchdog #(
    parameter int unsigned WAIT_TO = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic timeout
);

    localparam logic [15:0] LIMIT = 16'(WAIT_TO);

    logic [15:0] cnt;

    // Busy-run counter; holds at LIMIT so it cannot wrap during a long stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!busy) begin
            cnt <= '0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 16'd1;
        end
    end

    // Sticky flag, set on the same edge the count reaches LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (busy && (cnt >= LIMIT - 16'd1)) begin
            timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Optional interrupt entry sequencing is built when PIPE_CTRL_IRQ_EN is defined.
//
//   state  | meaning
//   RUN    | normal issue; hazard priority busy > mispredict > spart > load-use
//   SAVE   | write return PC to R15 via store_current, pulse irq_ack
//   VECTOR | redirect fetch to the interrupt vector, squash IF/ID and ID/EX
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TO = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] id_p0_addr,
    input  logic [3:0] id_p1_addr,
    input  logic       id_p0_used,
    input  logic       id_p1_used,
    input  logic       ex_mem_re,
    input  logic [3:0] ex_dst_addr,
    input  logic       ex_send,
    input  logic       spart_full,
    input  logic       ex_mispredict,
    input  logic       mem_busy,
    input  logic       irq,
    input  logic       irq_en,
    output logic       pc_hold,
    output logic [1:0] pc_sel,
    output logic       if_id_stall,
    output logic       if_id_flush,
    output logic       id_ex_stall,
    output logic       id_ex_flush,
    output logic       store_current,
    output logic       ex_mem_stall,
    output logic       ex_mem_flush,
    output logic       irq_ack,
    output logic       mem_timeout
);

    pctl_state_t state;
    pctl_state_t next_state;
    pctl_state_t cur;

    logic busy;
    logic mp;
    logic lu;
    logic sp;
    logic irq_go;

    assign busy = mem_busy;
    assign mp   = ex_mispredict;
    assign sp   = ex_send & spart_full;
    assign lu   = ex_mem_re & ((id_p0_used & (id_p0_addr == ex_dst_addr)) |
                               (id_p1_used & (id_p1_addr == ex_dst_addr)));

`ifdef PIPE_CTRL_IRQ_EN
    assign irq_go = irq & irq_en & ~busy & ~mp & ~sp & ~lu;
`else
    logic unused_irq;
    assign unused_irq = irq & irq_en;
    assign irq_go     = 1'b0;
`endif

    // While rst is high the outputs follow the RUN rules whatever is registered.
    assign cur = rst ? RUN : state;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a memory stall freezes the interrupt sequence in place.
    always_comb begin
        next_state = state;
        unique case (state)
            RUN:     if (irq_go) next_state = SAVE;
            SAVE:    if (!busy)  next_state = VECTOR;
            VECTOR:  if (!busy)  next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Mealy control outputs from current state and hazard conditions.
    always_comb begin
        pc_hold       = 1'b0;
        pc_sel        = PC_SEL_SEQ;
        if_id_stall   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_stall   = 1'b0;
        id_ex_flush   = 1'b0;
        store_current = 1'b0;
        ex_mem_stall  = 1'b0;
        ex_mem_flush  = 1'b0;
        irq_ack       = 1'b0;
        if (busy) begin
            pc_hold      = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end
        unique case (cur)
            SAVE: begin
`ifdef PIPE_CTRL_IRQ_EN
                // R15 write stays pending through a stall; ack only on advance.
                store_current = 1'b1;
                if (!busy) begin
                    pc_hold     = 1'b1;
                    if_id_flush = 1'b1;
                    irq_ack     = 1'b1;
                end
`endif
            end
            VECTOR: begin
                if (!busy) begin
                    pc_sel      = PC_SEL_VEC;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
            end
            default: begin
                if (!busy) begin
                    if (mp) begin
                        pc_sel      = PC_SEL_BR;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (sp) begin
                        pc_hold      = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_stall  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (lu) begin
                        pc_hold     = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
            end
        endcase
    end

    mem_watchdog #(
        .WAIT_TO (WAIT_TO)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .busy    (busy),
        .timeout (mem_timeout)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; interrupt checks depend on PIPE_CTRL_IRQ_EN.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] id_p0_addr, id_p1_addr, ex_dst_addr;
    logic       id_p0_used, id_p1_used, ex_mem_re, ex_send, spart_full;
    logic       ex_mispredict, mem_busy, irq, irq_en;
    logic       pc_hold, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
    logic       store_current, ex_mem_stall, ex_mem_flush, irq_ack, mem_timeout;
    logic [1:0] pc_sel;

    int pass_cnt = 0;
    int total    = 0;

    // {pc_hold, pc_sel[1:0], if_id_stall, if_id_flush, id_ex_stall,
    //  id_ex_flush, store_current, ex_mem_stall, ex_mem_flush, irq_ack}
    logic [10:0] ctl;
    assign ctl = {pc_hold, pc_sel, if_id_stall, if_id_flush, id_ex_stall,
                  id_ex_flush, store_current, ex_mem_stall, ex_mem_flush, irq_ack};

    localparam logic [10:0] C_IDLE  = 11'b0_00_0_0_0_0_0_0_0_0;
    localparam logic [10:0] C_LU    = 11'b1_00_1_0_0_1_0_0_0_0;
    localparam logic [10:0] C_MP    = 11'b0_01_0_1_0_1_0_0_0_0;
    localparam logic [10:0] C_BUSY  = 11'b1_00_1_0_1_0_0_1_0_0;
    localparam logic [10:0] C_SP    = 11'b1_00_1_0_1_0_0_0_1_0;
    localparam logic [10:0] C_SAVE  = 11'b1_00_0_1_0_0_1_0_0_1;
    localparam logic [10:0] C_SAVEB = 11'b1_00_1_0_1_0_1_1_0_0;
    localparam logic [10:0] C_VEC   = 11'b0_10_0_1_0_1_0_0_0_0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.WAIT_TO(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_p0_addr    (id_p0_addr),
        .id_p1_addr    (id_p1_addr),
        .id_p0_used    (id_p0_used),
        .id_p1_used    (id_p1_used),
        .ex_mem_re     (ex_mem_re),
        .ex_dst_addr   (ex_dst_addr),
        .ex_send       (ex_send),
        .spart_full    (spart_full),
        .ex_mispredict (ex_mispredict),
        .mem_busy      (mem_busy),
        .irq           (irq),
        .irq_en        (irq_en),
        .pc_hold       (pc_hold),
        .pc_sel        (pc_sel),
        .if_id_stall   (if_id_stall),
        .if_id_flush   (if_id_flush),
        .id_ex_stall   (id_ex_stall),
        .id_ex_flush   (id_ex_flush),
        .store_current (store_current),
        .ex_mem_stall  (ex_mem_stall),
        .ex_mem_flush  (ex_mem_flush),
        .irq_ack       (irq_ack),
        .mem_timeout   (mem_timeout)
    );

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic quiet();
        id_p0_addr = 4'd0; id_p1_addr = 4'd0; ex_dst_addr = 4'd0;
        id_p0_used = 1'b0; id_p1_used = 1'b0; ex_mem_re = 1'b0;
        ex_send = 1'b0; spart_full = 1'b0; ex_mispredict = 1'b0;
        mem_busy = 1'b0; irq = 1'b0; irq_en = 1'b0;
    endtask

    // Advance to just after the next rising edge; caller then drives and settles.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_lu();
        ex_mem_re = 1'b1; ex_dst_addr = 4'd3; id_p1_addr = 4'd3; id_p1_used = 1'b1;
    endtask

    initial begin
        quiet();
        rst = 1'b1;
        cyc(); cyc();
        settle();
        chk("reset_ctl", ctl, C_IDLE);
        chk("reset_timeout", {10'd0, mem_timeout}, 11'd0);

        cyc(); rst = 1'b0; settle();
        chk("idle", ctl, C_IDLE);

        // load-use through port 1, only for that cycle
        cyc(); set_lu(); settle();
        chk("lu_p1", ctl, C_LU);
        cyc(); quiet(); settle();
        chk("lu_release", ctl, C_IDLE);

        // address match on an unused source is not a hazard
        cyc(); ex_mem_re = 1'b1; ex_dst_addr = 4'd7; id_p1_addr = 4'd7; settle();
        chk("lu_unused_src", ctl, C_IDLE);
        // load-use through port 0
        cyc(); id_p0_addr = 4'd7; id_p0_used = 1'b1; settle();
        chk("lu_p0", ctl, C_LU);
        // same match but EX is not a load
        cyc(); ex_mem_re = 1'b0; settle();
        chk("no_load", ctl, C_IDLE);

        // mispredict outranks load-use
        cyc(); quiet(); set_lu(); ex_mispredict = 1'b1; settle();
        chk("mp_over_lu", ctl, C_MP);

        // busy for 3 cycles freezes a pending mispredict
        cyc(); quiet(); ex_mispredict = 1'b1; mem_busy = 1'b1; settle();
        chk("busy_mp_c1", ctl, C_BUSY);
        cyc(); settle();
        chk("busy_mp_c2", ctl, C_BUSY);
        cyc(); settle();
        chk("busy_mp_c3", ctl, C_BUSY);
        cyc(); mem_busy = 1'b0; settle();
        chk("busy_mp_c4", ctl, C_MP);
        chk("no_timeout_3", {10'd0, mem_timeout}, 11'd0);

        // SPART full for 2 cycles, released on cycle 3
        cyc(); quiet(); ex_send = 1'b1; spart_full = 1'b1; settle();
        chk("sp_c1", ctl, C_SP);
        cyc(); settle();
        chk("sp_c2", ctl, C_SP);
        cyc(); spart_full = 1'b0; settle();
        chk("sp_release", ctl, C_IDLE);
        cyc(); spart_full = 1'b1; set_lu(); settle();
        chk("sp_over_lu", ctl, C_SP);
        cyc(); mem_busy = 1'b1; settle();
        chk("busy_over_sp", ctl, C_BUSY);

`ifdef PIPE_CTRL_IRQ_EN
        // clean interrupt entry
        cyc(); quiet(); irq = 1'b1; irq_en = 1'b1; settle();
        chk("irq_accept", ctl, C_IDLE);
        cyc(); irq = 1'b0; settle();
        chk("irq_save", ctl, C_SAVE);
        cyc(); settle();
        chk("irq_vector", ctl, C_VEC);
        cyc(); settle();
        chk("irq_run", ctl, C_IDLE);

        // masked request, then a request blocked by load-use
        cyc(); irq = 1'b1; irq_en = 1'b0; settle();
        cyc(); settle();
        chk("irq_masked", ctl, C_IDLE);
        cyc(); irq_en = 1'b1; set_lu(); settle();
        chk("irq_blocked_lu", ctl, C_LU);
        cyc(); quiet(); settle();
        chk("irq_blocked_next", ctl, C_IDLE);

        // busy inside SAVE delays irq_ack
        cyc(); irq = 1'b1; irq_en = 1'b1; settle();
        cyc(); quiet(); mem_busy = 1'b1; settle();
        chk("save_busy_c1", ctl, C_SAVEB);
        cyc(); settle();
        chk("save_busy_c2", ctl, C_SAVEB);
        cyc(); mem_busy = 1'b0; settle();
        chk("save_after_busy", ctl, C_SAVE);
        cyc(); settle();
        chk("vector_after_busy", ctl, C_VEC);

        // reset in the middle of SAVE
        cyc(); irq = 1'b1; irq_en = 1'b1; settle();
        cyc(); quiet(); rst = 1'b1; settle();
        chk("rst_in_save", ctl, C_IDLE);
        cyc(); rst = 1'b0; settle();
        chk("rst_save_run", ctl, C_IDLE);
`else
        // interrupt pins have no effect in this build
        cyc(); quiet(); irq = 1'b1; irq_en = 1'b1; settle();
        chk("irq_ignored_c1", ctl, C_IDLE);
        cyc(); settle();
        chk("irq_ignored_c2", ctl, C_IDLE);
        cyc(); settle();
        chk("irq_ignored_c3", ctl, C_IDLE);
`endif

        // watchdog with WAIT_TO=4
        cyc(); quiet(); mem_busy = 1'b1; settle();
        cyc(); settle();
        cyc(); settle();
        cyc(); settle();
        chk("wd_before_limit", {10'd0, mem_timeout}, 11'd0);
        cyc(); mem_busy = 1'b0; settle();
        chk("wd_set", {10'd0, mem_timeout}, 11'd1);
        cyc(); settle();
        cyc(); settle();
        chk("wd_sticky", {10'd0, mem_timeout}, 11'd1);
        chk("wd_idle_ctl", ctl, C_IDLE);
        cyc(); rst = 1'b1; settle();
        cyc(); rst = 1'b0; settle();
        chk("wd_cleared", {10'd0, mem_timeout}, 11'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage processor pipeline. Watches decode, execute and memory stage status each cycle and drives the stall, flush and store-current controls of the IF/ID, ID/EX and EX/MEM pipeline registers, plus the PC next-address select. It also sequences interrupt entry: it saves the return PC into R15 through the ID/EX store-current path, then redirects fetch to the interrupt vector.

## Interface
- WAIT_TO, 255: consecutive mem_busy cycles before mem_timeout sets; legal range 1..65535.
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, synchronous, active-high.
- id_p0_addr, id_p1_addr  in  4  source register addresses of the instruction in ID.
- id_p0_used, id_p1_used  in  1  source actually read by the ID instruction.
- ex_mem_re  in  1  instruction in EX is a load.
- ex_dst_addr  in  4  destination of the EX instruction.
- ex_send  in  1  EX instruction sends to SPART.
- spart_full  in  1  SPART transmit buffer full.
- ex_mispredict  in  1  branch resolved in EX disagrees with prediction.
- mem_busy  in  1  data or instruction memory not ready this cycle.
- irq, irq_en  in  1  interrupt request level; global interrupt enable.
- pc_hold  out  1  PC register keeps its value.
- pc_sel  out  2  00 sequential/predicted, 01 EX branch target, 10 vector, 11 unused.
- if_id_stall, if_id_flush  out  1  IF/ID hold; IF/ID clear to NOP.
- id_ex_stall, id_ex_flush  out  1  ID/EX hold; ID/EX bubble.
- store_current  out  1  ID/EX loads R15 write of the current instruction address.
- ex_mem_stall, ex_mem_flush  out  1  EX/MEM hold; EX/MEM bubble.
- irq_ack  out  1  one-cycle pulse when interrupt entry commits.
- mem_timeout  out  1  sticky watchdog error.

## Operation
- Conditions: busy = mem_busy; mp = ex_mispredict; lu = ex_mem_re & ((id_p0_used & id_p0_addr==ex_dst_addr) | (id_p1_used & id_p1_addr==ex_dst_addr)); sp = ex_send & spart_full.
- Priority in RUN, highest first:
  - busy: pc_hold, if_id_stall, id_ex_stall, ex_mem_stall; no flushes.
  - mp: pc_sel=01, if_id_flush, id_ex_flush; lu ignored.
  - sp: pc_hold, if_id_stall, id_ex_stall, ex_mem_flush.
  - lu: pc_hold, if_id_stall, id_ex_flush.
  - None active: all controls 0, pc_sel=00.
- FSM states RUN, SAVE, VECTOR.
  - RUN→SAVE when irq & irq_en & !busy & !mp & !sp & !lu.
  - SAVE, 1 cycle: store_current, pc_hold, if_id_flush, irq_ack.
  - VECTOR, 1 cycle: pc_sel=10, if_id_flush, id_ex_flush.
  - VECTOR→RUN.
- busy in SAVE or VECTOR: the state holds and the busy freeze outputs apply. In SAVE, store_current stays asserted but irq_ack is suppressed until the cycle SAVE actually advances.
- Watchdog: the counter increments on each busy cycle and clears on !busy. At count==WAIT_TO, mem_timeout sets and stays set until rst. The counter saturates.

## Timing
- Control outputs are combinational (Mealy) from the current inputs and registered state. Hazard response latency is 0 cycles.
- Interrupt entry costs 2 cycles (SAVE, VECTOR). The first vector instruction is in IF/ID 2 cycles after the request is accepted.
- Reset values: state RUN, watchdog count 0, mem_timeout 0, irq_ack 0, pc_sel 00. The stall, flush and store_current outputs follow the RUN rules.
- rst mid-SAVE or mid-VECTOR returns to RUN next cycle with no irq_ack.
- irq deasserting after entering SAVE does not abort the sequence.

## Configuration
- PIPE_CTRL_IRQ_EN defined: SAVE/VECTOR sequencing and irq_ack are present.
- PIPE_CTRL_IRQ_EN undefined: the FSM is fixed in RUN. irq and irq_en are ignored, and store_current and irq_ack are tied 0. Hazard and watchdog behaviour are identical in both builds.

## Structure
- Package pipe_ctrl_pkg holds:
  - Enum pctl_state_t (RUN, SAVE, VECTOR).
  - Constants PC_SEL_SEQ=2'b00, PC_SEL_BR=2'b01, PC_SEL_VEC=2'b10.
  - Constant R15_ADDR=4'hf.
- Sub-module mem_watchdog: parameterised saturating counter plus sticky flag, instantiated once.

## Test plan
- ex_mem_re=1, ex_dst_addr=3, id_p1_addr=3, id_p1_used=1 → pc_hold=1, if_id_stall=1, id_ex_flush=1 for exactly that cycle.
- ex_mispredict=1 together with the load-use case above → pc_sel=01, if_id_flush=1, id_ex_flush=1, pc_hold=0.
- mem_busy=1 for 3 cycles with ex_mispredict=1 → all three stalls held 3 cycles, then a flush with pc_sel=01 on cycle 4.
- ex_send=1, spart_full=1 for 2 cycles → id_ex_stall=1 and ex_mem_flush=1 both cycles; released on cycle 3.
- irq=1, irq_en=1, pipeline idle → next cycle store_current=1 and irq_ack=1; following cycle pc_sel=10; RUN after. With mem_busy=1 during SAVE, irq_ack is delayed until busy drops.
- WAIT_TO=4, mem_busy held 4 cycles → mem_timeout=1 stays high after busy drops, and clears only on rst.
